// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared widths, reset PC default and prefetch entry type for instr_fetch
package fetch_pkg;

  localparam int DATA_WIDTH        = 16;
  localparam int ADDRESS_WIDTH     = 16;
  localparam int INSTRUCTION_WIDTH = 15;

  localparam logic [ADDRESS_WIDTH-1:0] DEFAULT_RESET_PC = 16'h0000;

  typedef struct packed {
    logic [ADDRESS_WIDTH-1:0] pc;
    logic [DATA_WIDTH-1:0]    word;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// rtl/fetch_fifo.sv - prefetch FIFO of {pc, word} entries with synchronous clear
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     clear_i,
  input  logic                     push_i,
  input  fetch_entry_t             push_data_i,
  input  logic                     pop_i,
  output fetch_entry_t             head_o,
  output logic                     empty_o,
  output logic                     full_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int AW = $clog2(DEPTH);

  fetch_entry_t    mem_q [DEPTH];
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [AW:0]     count_q, count_d;
  logic            do_push, do_pop;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == (AW+1)'(DEPTH));
  assign do_push = push_i && !full_o && !clear_i;
  assign do_pop  = pop_i && !empty_o && !clear_i;
  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (clear_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      count_d = count_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: nothing is read until count says it was written.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data_i;
  end

  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    !(push_i && full_o && !clear_i));

endmodule

// File: rtl/instr_fetch.sv
// rtl/instr_fetch.sv - PC, request issue and response tracking in front of the prefetch FIFO
module instr_fetch
  import fetch_pkg::*;
#(
  parameter int                       FIFO_DEPTH = 4,
  parameter logic [ADDRESS_WIDTH-1:0] RESET_PC   = DEFAULT_RESET_PC
) (
  input  logic                         clk,
  input  logic                         rst_n,
  output logic                         mem_req,
  output logic [ADDRESS_WIDTH-1:0]     mem_addr,
  input  logic [DATA_WIDTH-1:0]        mem_rdata,
  input  logic                         mem_rvalid,
  input  logic                         core_busy,
  input  logic                         redirect_en,
  input  logic [ADDRESS_WIDTH-1:0]     redirect_addr,
  output logic [INSTRUCTION_WIDTH-1:0] instruction,
  output logic                         instr_valid,
  output logic [ADDRESS_WIDTH-1:0]     instr_pc
);

  localparam int            CW          = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CW:0]   DEPTH_LIMIT = (CW+1)'(FIFO_DEPTH);

  logic [ADDRESS_WIDTH-1:0] fetch_pc_q, fetch_pc_d;
  logic [CW-1:0]            outstanding_q, outstanding_d;
  logic [CW-1:0]            discard_q, discard_d;
  logic [CW-1:0]            fifo_count;
  logic                     fifo_empty, fifo_full_unused;
  logic                     fifo_push, fifo_pop, rsp_drop;
  fetch_entry_t             push_entry, head_entry;
  logic [DATA_WIDTH-INSTRUCTION_WIDTH-1:0] rsvd_bits_unused;

  assign mem_req  = rst_n && !redirect_en &&
                    (({1'b0, fifo_count} + {1'b0, outstanding_q}) < DEPTH_LIMIT);
  assign mem_addr = fetch_pc_q;

  assign rsp_drop  = mem_rvalid && (discard_q != '0);
  assign fifo_push = mem_rvalid && !rsp_drop && !redirect_en;
  assign fifo_pop  = instr_valid && !core_busy && !redirect_en;

  // In-order memory: once stale responses are drained, the oldest live request sits this far behind the PC.
  assign push_entry = '{pc: fetch_pc_q - ADDRESS_WIDTH'(outstanding_q), word: mem_rdata};

  fetch_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk         (clk),
    .rst_n       (rst_n),
    .clear_i     (redirect_en),
    .push_i      (fifo_push),
    .push_data_i (push_entry),
    .pop_i       (fifo_pop),
    .head_o      (head_entry),
    .empty_o     (fifo_empty),
    .full_o      (fifo_full_unused),
    .count_o     (fifo_count)
  );

  assign instr_valid      = !fifo_empty;
  assign instruction      = instr_valid ? head_entry.word[INSTRUCTION_WIDTH-1:0] : '0;
  assign instr_pc         = instr_valid ? head_entry.pc : RESET_PC;
  assign rsvd_bits_unused = head_entry.word[DATA_WIDTH-1:INSTRUCTION_WIDTH];

  always_comb begin
    fetch_pc_d    = fetch_pc_q;
    discard_d     = discard_q;
    outstanding_d = outstanding_q + CW'(mem_req) - CW'(mem_rvalid);
    if (mem_req)  fetch_pc_d = fetch_pc_q + ADDRESS_WIDTH'(1);
    if (rsp_drop) discard_d  = discard_q - CW'(1);
    if (redirect_en) begin
      fetch_pc_d = redirect_addr;
      discard_d  = outstanding_q - CW'(mem_rvalid);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_pc_q    <= RESET_PC;
      outstanding_q <= '0;
      discard_q     <= '0;
    end else begin
      fetch_pc_q    <= fetch_pc_d;
      outstanding_q <= outstanding_d;
      discard_q     <= discard_d;
    end
  end

endmodule

// File: tb/tb_instr_fetch.sv
// tb/tb_instr_fetch.sv - directed bench for instr_fetch with a fixed-latency memory model
module tb_instr_fetch;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        mem_req;
  logic [15:0] mem_addr;
  logic [15:0] mem_rdata;
  logic        mem_rvalid;
  logic        core_busy;
  logic        redirect_en;
  logic [15:0] redirect_addr;
  logic [14:0] instruction;
  logic        instr_valid;
  logic [15:0] instr_pc;

  always #5 clk = ~clk;

  instr_fetch dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .mem_req       (mem_req),
    .mem_addr      (mem_addr),
    .mem_rdata     (mem_rdata),
    .mem_rvalid    (mem_rvalid),
    .core_busy     (core_busy),
    .redirect_en   (redirect_en),
    .redirect_addr (redirect_addr),
    .instruction   (instruction),
    .instr_valid   (instr_valid),
    .instr_pc      (instr_pc)
  );

  int n_cmp = 0;
  int n_mis = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // memory model: slot 0 is the response driven this cycle
  logic        sv [8];
  logic [15:0] sa [8];
  int          lat;

  function automatic logic [15:0] mem_word(input logic [15:0] a);
    logic [15:0] t;
    t = (a << 1) | 16'h0001;
    return {(a >= 16'h0040), t[14:0]};
  endfunction

  logic        lr [64];
  logic        lv [64];
  logic [15:0] la [64];
  logic [15:0] lp [64];
  int          cyc;
  logic [15:0] dq_pc [$];
  logic [14:0] dq_ins [$];

  task automatic tick();
    logic        s_req;
    logic [15:0] s_addr;
    #1;
    s_req  = mem_req;
    s_addr = mem_addr;
    if (cyc < 64) begin
      lr[cyc] = mem_req;
      la[cyc] = mem_addr;
      lv[cyc] = instr_valid;
      lp[cyc] = instr_pc;
    end
    if (instr_valid && !core_busy && !redirect_en) begin
      dq_pc.push_back(instr_pc);
      dq_ins.push_back(instruction);
    end
    cyc++;
    @(posedge clk);
    #1;
    for (int i = 0; i < 7; i++) begin
      sv[i] = sv[i+1];
      sa[i] = sa[i+1];
    end
    sv[7] = 1'b0;
    if (s_req) begin
      sv[lat-1] = 1'b1;
      sa[lat-1] = s_addr;
    end
    mem_rvalid = sv[0];
    mem_rdata  = sv[0] ? mem_word(sa[0]) : 16'h0000;
  endtask

  task automatic do_reset(input int l);
    rst_n         = 1'b0;
    core_busy     = 1'b0;
    redirect_en   = 1'b0;
    redirect_addr = 16'h0000;
    lat           = l;
    for (int i = 0; i < 8; i++) begin
      sv[i] = 1'b0;
      sa[i] = 16'h0000;
    end
    mem_rvalid = 1'b0;
    tick();
    tick();
    dq_pc.delete();
    dq_ins.delete();
    rst_n = 1'b1;
    cyc   = 0;
  endtask

  function automatic logic [15:0] dpc(input int i);
    return (i < dq_pc.size()) ? dq_pc[i] : 16'hDEAD;
  endfunction

  function automatic logic [14:0] dins(input int i);
    return (i < dq_ins.size()) ? dq_ins[i] : 15'h7BAD;
  endfunction

  logic [14:0] exp_t1  [4] = '{15'h0001, 15'h0003, 15'h0005, 15'h0007};
  logic [15:0] exp_wpc [4] = '{16'hFFFE, 16'hFFFF, 16'h0000, 16'h0001};
  logic [14:0] exp_wi  [4] = '{15'h7FFD, 15'h7FFF, 15'h0001, 15'h0003};
  int          nreq;

  initial begin
    rst_n = 1'b0; core_busy = 1'b0; redirect_en = 1'b0; redirect_addr = 16'h0000;
    mem_rvalid = 1'b0; mem_rdata = 16'h0000; lat = 1; cyc = 0;
    for (int i = 0; i < 8; i++) begin sv[i] = 1'b0; sa[i] = 16'h0000; end
    #2;
    check_eq("rst_mem_req", mem_req, 0);
    check_eq("rst_mem_addr", mem_addr, 16'h0000);
    check_eq("rst_valid", instr_valid, 0);
    check_eq("rst_instruction", instruction, 0);
    check_eq("rst_instr_pc", instr_pc, 16'h0000);

    // stream after reset, latency 1
    do_reset(1);
    repeat (8) tick();
    for (int i = 0; i < 4; i++) begin
      check_eq($sformatf("t1_req%0d", i), lr[i], 1);
      check_eq($sformatf("t1_addr%0d", i), la[i], i);
      check_eq($sformatf("t1_pc%0d", i), dpc(i), i);
      check_eq($sformatf("t1_ins%0d", i), dins(i), exp_t1[i]);
    end
    check_eq("t1_valid_c1", lv[1], 0);
    check_eq("t1_valid_c2", lv[2], 1);

    // core busy for 10 cycles
    do_reset(1);
    core_busy = 1'b1;
    repeat (10) tick();
    nreq = 0;
    for (int i = 0; i < 10; i++) nreq += int'(lr[i]);
    check_eq("t2_req_count", nreq, 4);
    check_eq("t2_req_c9", lr[9], 0);
    check_eq("t2_valid_c9", lv[9], 1);
    check_eq("t2_head_pc", lp[9], 16'h0000);
    check_eq("t2_none_delivered", dq_pc.size(), 0);
    core_busy = 1'b0;
    repeat (8) tick();
    for (int i = 0; i < 6; i++) begin
      check_eq($sformatf("t2_pc%0d", i), dpc(i), i);
      check_eq($sformatf("t2_ins%0d", i), dins(i), 2 * i + 1);
    end

    // latency 3, redirect with 3 outstanding
    do_reset(3);
    repeat (3) tick();
    redirect_en = 1'b1; redirect_addr = 16'h0040;
    tick();
    redirect_en = 1'b0;
    repeat (8) tick();
    check_eq("t3_req_redirect", lr[3], 0);
    check_eq("t3_req_after", lr[4], 1);
    check_eq("t3_addr_after", la[4], 16'h0040);
    check_eq("t3_valid_c4", lv[4], 0);
    check_eq("t3_valid_c7", lv[7], 0);
    check_eq("t3_valid_c8", lv[8], 1);
    check_eq("t3_pc0", dpc(0), 16'h0040);
    check_eq("t3_ins0", dins(0), 15'h0081);
    check_eq("t3_pc1", dpc(1), 16'h0041);
    check_eq("t3_ins1", dins(1), 15'h0083);
    check_eq("t3_pc2", dpc(2), 16'h0042);

    // redirect in the same cycle as a pop
    do_reset(1);
    repeat (2) tick();
    redirect_en = 1'b1; redirect_addr = 16'h0010;
    tick();
    redirect_en = 1'b0;
    repeat (6) tick();
    check_eq("t4_valid_redir", lv[2], 1);
    check_eq("t4_head_redir", lp[2], 16'h0000);
    check_eq("t4_valid_next", lv[3], 0);
    check_eq("t4_addr_next", la[3], 16'h0010);
    check_eq("t4_pc0", dpc(0), 16'h0010);
    check_eq("t4_ins0", dins(0), 15'h0021);
    check_eq("t4_pc1", dpc(1), 16'h0011);

    // PC wrap, redirect from a running stream
    dq_pc.delete(); dq_ins.delete();
    redirect_en = 1'b1; redirect_addr = 16'hFFFE;
    tick();
    redirect_en = 1'b0;
    repeat (8) tick();
    for (int i = 0; i < 4; i++) begin
      check_eq($sformatf("t5_pc%0d", i), dpc(i), exp_wpc[i]);
      check_eq($sformatf("t5_ins%0d", i), dins(i), exp_wi[i]);
    end

    // reset mid-stream: 2 outstanding, FIFO half full
    do_reset(2);
    core_busy = 1'b1;
    repeat (4) tick();
    #3;
    check_eq("t6_valid_before", instr_valid, 1);
    rst_n = 1'b0;
    #1;
    check_eq("t6_valid_rst", instr_valid, 0);
    check_eq("t6_req_rst", mem_req, 0);
    check_eq("t6_addr_rst", mem_addr, 16'h0000);
    check_eq("t6_pc_rst", instr_pc, 16'h0000);
    do_reset(1);
    repeat (6) tick();
    check_eq("t6_req0", lr[0], 1);
    check_eq("t6_addr0", la[0], 16'h0000);
    check_eq("t6_valid_c2", lv[2], 1);
    check_eq("t6_pc0", dpc(0), 16'h0000);
    check_eq("t6_pc1", dpc(1), 16'h0001);
    check_eq("t6_ins1", dins(1), 15'h0003);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
